// File: rtl/wb_sched_pkg.sv
// Shared widths, status codes, register ids and FSM encodings for the
// write-back scheduler.
package wb_sched_pkg;

   localparam int NIBBLE = 4;
   localparam int D_WORD = 64;

   localparam logic [NIBBLE-1:0] STAT_AOK = 4'h1;
   localparam logic [NIBBLE-1:0] STAT_HLT = 4'h2;
   localparam logic [NIBBLE-1:0] STAT_ADR = 4'h3;
   localparam logic [NIBBLE-1:0] STAT_INS = 4'h4;

   localparam logic [NIBBLE-1:0] RNONE = 4'hF;
   localparam logic [NIBBLE-1:0] INOP  = 4'h1;

   localparam logic [1:0] WBS_NORMAL = 2'd0;
   localparam logic [1:0] WBS_SECOND = 2'd1;
   localparam logic [1:0] WBS_HALT   = 2'd2;

   // Status values that stop the machine; anything outside AOK..INS is a bubble.
   function automatic logic is_fault(input logic [NIBBLE-1:0] stat);
      return (stat == STAT_HLT) || (stat == STAT_ADR) || (stat == STAT_INS);
   endfunction

endpackage

// File: rtl/wb_sched.sv
// Write-back scheduler: serializes dual register-file writes onto the single
// write port, tracks architectural status/halt and counts retired instructions.
module wb_sched
   import wb_sched_pkg::*;
(
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic [NIBBLE-1:0] W_stat_i,
   input  logic [NIBBLE-1:0] W_icode_i,
   input  logic [D_WORD-1:0] W_valE_i,
   input  logic [D_WORD-1:0] W_valM_i,
   input  logic [NIBBLE-1:0] W_dstE_i,
   input  logic [NIBBLE-1:0] W_dstM_i,
   output logic              rf_we_o,
   output logic [NIBBLE-1:0] rf_waddr_o,
   output logic [D_WORD-1:0] rf_wdata_o,
   output logic              wb_stall_o,
   output logic [NIBBLE-1:0] cpu_stat_o,
   output logic              halted_o,
   output logic [D_WORD-1:0] instret_o
);

   logic [1:0]        r_state;
   logic [NIBBLE-1:0] r_stat;
   logic [D_WORD-1:0] r_instret;
   logic [NIBBLE-1:0] r_cap_dst;
   logic [D_WORD-1:0] r_cap_val;

   logic [1:0]        w_next_state;
   logic              w_we;
   logic [NIBBLE-1:0] w_waddr;
   logic [D_WORD-1:0] w_wdata;
   logic              w_stall;
   logic              w_capture;
   logic              w_retire;
   logic              w_fault;
   logic              w_has_e;
   logic              w_has_m;

   assign w_has_e = (W_dstE_i != RNONE);
   assign w_has_m = (W_dstM_i != RNONE);

   always_comb begin
      w_next_state = r_state;
      w_we         = 1'b0;
      w_waddr      = RNONE;
      w_wdata      = '0;
      w_stall      = 1'b0;
      w_capture    = 1'b0;
      w_retire     = 1'b0;
      w_fault      = 1'b0;
      case (r_state)
         WBS_NORMAL: begin
            if (W_stat_i == STAT_AOK) begin
               if (w_has_e && w_has_m && (W_dstE_i != W_dstM_i)) begin
                  // valE goes now; valM is parked and written next cycle.
                  w_we         = 1'b1;
                  w_waddr      = W_dstE_i;
                  w_wdata      = W_valE_i;
                  w_stall      = 1'b1;
                  w_capture    = 1'b1;
                  w_next_state = WBS_SECOND;
               end else begin
                  if (w_has_m) begin
                     w_we    = 1'b1;
                     w_waddr = W_dstM_i;
                     w_wdata = W_valM_i;
                  end else if (w_has_e) begin
                     w_we    = 1'b1;
                     w_waddr = W_dstE_i;
                     w_wdata = W_valE_i;
                  end
                  w_retire = (W_icode_i != INOP);
               end
            end else if (is_fault(W_stat_i)) begin
               w_fault      = 1'b1;
               w_next_state = WBS_HALT;
            end
         end
         WBS_SECOND: begin
            w_we         = 1'b1;
            w_waddr      = r_cap_dst;
            w_wdata      = r_cap_val;
            w_retire     = 1'b1;
            w_next_state = WBS_NORMAL;
         end
         WBS_HALT: begin
            w_stall = 1'b1;
         end
         default: begin
            w_next_state = WBS_NORMAL;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state   <= WBS_NORMAL;
         r_stat    <= STAT_AOK;
         r_instret <= '0;
         r_cap_dst <= RNONE;
         r_cap_val <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_fault) begin
            r_stat <= W_stat_i;
         end
         if (w_retire) begin
            r_instret <= r_instret + 64'd1;
         end
         if (w_capture) begin
            r_cap_dst <= W_dstM_i;
            r_cap_val <= W_valM_i;
         end
      end
   end

   assign rf_we_o    = w_we;
   assign rf_waddr_o = w_waddr;
   assign rf_wdata_o = w_wdata;
   assign wb_stall_o = w_stall;
   assign cpu_stat_o = r_stat;
   assign halted_o   = (r_state == WBS_HALT);
   assign instret_o  = r_instret;

endmodule
